// File: rtl/seq101_frame_tx.sv
// Serial frame transmitter: sync marker 1,0,1, payload MSB first, odd parity, guard 0.
// All outputs come straight from flops; they are computed from the next state.
module seq101_frame_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              x_out,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSync  = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StPar   = 3'd3;
    localparam logic [2:0] StGuard = 3'd4;

    // One counter serves both the sync marker (0..2) and the payload (0..DATA_W-1).
    localparam int unsigned CntW = (DATA_W > 4) ? $clog2(DATA_W) : 2;
    localparam logic [CntW-1:0] SyncLast = CntW'(2);
    localparam logic [CntW-1:0] BitLast  = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] SyncZero = CntW'(1);

    logic [2:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              x_out_q, x_out_d;
    logic              x_valid_q, x_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSync;
                    cnt_d   = '0;
                    shreg_d = data;
                    par_d   = ~^data;
                end
            end
            StSync: begin
                if (cnt_q == SyncLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == BitLast) begin
                    state_d = StPar;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPar: begin
                state_d = StGuard;
            end
            StGuard: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                shreg_d = '0;
                par_d   = 1'b0;
            end
        endcase
    end

    // Outputs decode the state being entered, so they line up with it after the edge.
    always_comb begin
        x_out_d   = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            StSync: begin
                x_out_d   = (cnt_d != SyncZero);
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            StData: begin
                x_out_d   = shreg_d[DATA_W-1];
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            StPar: begin
                x_out_d   = par_d;
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
            StGuard: begin
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
                done_d    = 1'b1;
            end
            default: begin
                x_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq101_frame_tx.sv
// Bench for seq101_frame_tx: frame-level reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_seq101_frame_tx;

    localparam int unsigned W  = 8;
    localparam int          FL = W + 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data;
    logic         x_out, x_valid, busy, done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: position within the current frame (0 = idle) and the frame's bit list.
    int   m_pos = 0;
    logic m_frame[0:FL-1];

    logic fx[1:FL];
    logic fv[1:FL];
    logic fd[1:FL];

    always #5 clk = ~clk;

    seq101_frame_tx #(.DATA_W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data    (data),
        .x_out   (x_out),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0;
        end else if (m_pos != 0) begin
            m_pos = (m_pos == FL) ? 0 : m_pos + 1;
        end else if (start === 1'b1) begin
            m_frame[0] = 1'b1;
            m_frame[1] = 1'b0;
            m_frame[2] = 1'b1;
            for (int i = 0; i < int'(W); i++) m_frame[3 + i] = data[int'(W) - 1 - i];
            m_frame[W + 3] = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
            m_frame[W + 4] = 1'b0;
            m_pos = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic ex;
            ex = 1'b0;
            if (m_pos != 0) ex = m_frame[m_pos - 1];
            chk("model_x_out", 32'(x_out), 32'(ex));
            chk("model_x_valid", 32'(x_valid), 32'(m_pos != 0));
            chk("model_busy", 32'(busy), 32'(m_pos != 0));
            chk("model_done", 32'(done), 32'(m_pos == FL));
        end
    end

    // Caller is at a negedge in IDLE; returns at the negedge of cycle FL+1.
    task automatic run_frame(input logic [W-1:0] d, input int poke_cycle,
                             input logic [W-1:0] poke_data);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        for (int c = 1; c <= FL; c++) begin
            fx[c] = x_out;
            fv[c] = x_valid;
            fd[c] = done;
            start = (c == poke_cycle);
            data  = (c == poke_cycle) ? poke_data : W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [FL-1:0] exp_bits);
        logic [FL-1:0] gx, gv, gd;
        for (int c = 1; c <= FL; c++) begin
            gx = {gx[FL-2:0], fx[c]};
            gv = {gv[FL-2:0], fv[c]};
            gd = {gd[FL-2:0], fd[c]};
        end
        chk({tag, "_bits"}, 32'(gx), 32'(exp_bits));
        chk({tag, "_valid"}, 32'(gv), 32'({FL{1'b1}}));
        chk({tag, "_done"}, 32'(gd), 32'(1));
    endtask

    initial begin
        int   rise1, rise2, nrise, gap, zc, zat;
        logic prev, h1, h2, z;

        rst_n = 1'b1;
        start = 1'b0;
        data  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_x_out", 32'(x_out), 0);
        chk("reset_x_valid", 32'(x_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // A5 frame with an ignored start (data 3C) in cycle 5.
        run_frame(8'hA5, 5, 8'h3C);
        check_frame("a5", 13'b1011010010110);
        for (int i = 0; i < 6; i++) begin
            chk("no_second_frame", 32'(x_valid), 0);
            @(negedge clk);
        end

        run_frame(8'h01, 0, 8'h00);
        chk("parity_01", 32'(fx[12]), 0);
        run_frame(8'h00, 0, 8'h00);
        chk("parity_00", 32'(fx[12]), 1);
        run_frame(8'hFF, 0, 8'h00);
        chk("parity_ff", 32'(fx[12]), 1);

        // Start held high across edges T0..T27: exactly two frames.
        rise1 = -1;
        rise2 = -1;
        nrise = 0;
        gap   = 0;
        prev  = 1'b0;
        start = 1'b1;
        data  = 8'h5A;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 28) start = 1'b0;
            if (x_valid && !prev) begin
                nrise++;
                if (nrise == 1) rise1 = c;
                if (nrise == 2) rise2 = c;
            end
            if (nrise == 1 && !x_valid) gap++;
            prev = x_valid;
        end
        chk("b2b_first_sync", 32'(rise1), 1);
        chk("b2b_second_sync", 32'(rise2), 15);
        chk("b2b_frame_count", 32'(nrise), 2);
        chk("b2b_idle_gap", 32'(gap), 1);

        // Reset mid-frame in cycle 7.
        start = 1'b1;
        data  = 8'h96;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_x_out", 32'(x_out), 0);
        chk("abort_x_valid", 32'(x_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(8'hC3, 0, 8'h00);
        check_frame("c3", 13'b1011100001110);

        // Overlapping 101 Mealy detector fed by the line, idle history of zeros.
        run_frame(8'h00, 0, 8'h00);
        h1  = 1'b0;
        h2  = 1'b0;
        zc  = 0;
        zat = -1;
        for (int c = 1; c <= FL; c++) begin
            z = h2 & ~h1 & fx[c];
            if (z) begin
                zc++;
                zat = c;
            end
            h2 = h1;
            h1 = fx[c];
        end
        chk("detector_z_count", 32'(zc), 1);
        chk("detector_z_cycle", 32'(zat), 3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
